// File: rtl/ptr_synch_flags.sv
// Gray-pointer synchroniser plus occupancy/flag generator for one side of an async FIFO.
// Optional macro PTR_SYNCH_GRAY_CHK_EN adds a sticky multi-bit-change detector on the synchronised pointer.
module ptr_synch_flags #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0,
    parameter int ALMOST_TH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   remote_gray_i,
    input  logic [ADDR_W:0]   local_bin_i,
    output logic [ADDR_W:0]   remote_bin_o,
    output logic [ADDR_W:0]   level_o,
    output logic              flag_o,
    output logic              almost_o,
    output logic              valid_o,
    output logic              gray_err_o
);

    localparam int              PW      = ADDR_W + 1;
    localparam int              CNT_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0]   TH      = PW'(ALMOST_TH);
    localparam logic [PW-1:0]   HI_TH   = DEPTH - TH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES);

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0]  stage_r [SYNC_STAGES];
    logic [CNT_W-1:0] count_r;
    logic [ADDR_W:0]  raw_s;
    logic [ADDR_W:0]  level_s;

    // Synchroniser chain: stage 0 captures the remote Gray pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            stage_r[0] <= remote_gray_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // Warm-up counter saturating once the chain holds real samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Status decode; local pointer moves appear immediately so flags err on the safe side.
    always_comb begin
        remote_bin_o = gray2bin(stage_r[SYNC_STAGES-1]);
        valid_o      = (count_r == CNT_MAX);
        if (MODE == 0) begin
            raw_s = remote_bin_o - local_bin_i;
        end else begin
            raw_s = local_bin_i - remote_bin_o;
        end
        if (raw_s > DEPTH) begin
            level_s = DEPTH;
        end else begin
            level_s = raw_s;
        end
        if (!valid_o) begin
            level_o  = (MODE == 0) ? {PW{1'b0}} : DEPTH;
            flag_o   = 1'b1;
            almost_o = 1'b1;
        end else if (MODE == 0) begin
            level_o  = level_s;
            flag_o   = (level_s == {PW{1'b0}});
            almost_o = (level_s <= TH);
        end else begin
            level_o  = level_s;
            flag_o   = (level_s == DEPTH);
            almost_o = (level_s >= HI_TH);
        end
    end

`ifdef PTR_SYNCH_GRAY_CHK_EN
    function automatic logic multi_bit(input logic [ADDR_W:0] d);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i <= ADDR_W; i++) begin
            if (d[i] && seen) begin
                multi = 1'b1;
            end else if (d[i]) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
        return multi;
    endfunction

    logic [ADDR_W:0] prev_r;
    logic            armed_r;
    logic            gray_err_r;

    // Armed one cycle after valid so the first post-warm-up sample is not compared against reset zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_r     <= '0;
            armed_r    <= 1'b0;
            gray_err_r <= 1'b0;
        end else begin
            prev_r  <= stage_r[SYNC_STAGES-1];
            armed_r <= valid_o;
            if (armed_r && multi_bit(stage_r[SYNC_STAGES-1] ^ prev_r)) begin
                gray_err_r <= 1'b1;
            end else begin
                gray_err_r <= gray_err_r;
            end
        end
    end

    assign gray_err_o = gray_err_r;
`else
    assign gray_err_o = 1'b0;
`endif

endmodule

// File: doc/ptr_synch_flags.md
# ptr_synch_flags

Parametrised pointer synchroniser and FIFO status generator for dual-clock FIFOs. It brings a Gray-coded pointer from the remote clock domain into the local domain through a configurable-depth flip-flop chain and converts it back to binary. It compares the result with the local binary pointer, including the wrap bit, to produce occupancy, a full or empty flag and an almost-threshold flag. One instance sits on the read side (empty) and one on the write side (full) of each asynchronous FIFO.

## Interface
- ADDR_W, 4, address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits (MSB = wrap bit).
- SYNC_STAGES, 2, synchroniser flip-flop count; legal range 2..4.
- MODE, 0, 0 = read side (remote = write pointer, flag = empty); 1 = write side (remote = read pointer, flag = full).
- ALMOST_TH, 2, almost threshold in entries; legal range 0..2**ADDR_W.

Ports:
- clk  in  1  local-domain clock.
- rst  in  1  reset; one clock; synchronous, active-low.
- remote_gray_i  in  ADDR_W+1  remote pointer, Gray code, registered in the remote domain.
- local_bin_i  in  ADDR_W+1  local pointer, binary.
- remote_bin_o  out  ADDR_W+1  synchronised remote pointer, binary.
- level_o  out  ADDR_W+1  occupancy, 0..2**ADDR_W.
- flag_o  out  1  empty (MODE 0) or full (MODE 1).
- almost_o  out  1  almost-empty (MODE 0) or almost-full (MODE 1).
- valid_o  out  1  synchroniser warm-up complete.
- gray_err_o  out  1  sticky Gray-violation flag.

## Operation
- Sync chain: stage[0] samples remote_gray_i; stage[k] samples stage[k-1]. The last stage drives the Gray-to-binary conversion, which produces remote_bin_o.
- Level, modulo 2**(ADDR_W+1):
  - MODE 0: remote_bin_o - local_bin_i.
  - MODE 1: local_bin_i - remote_bin_o.
  - Raw values above 2**ADDR_W are illegal. level_o saturates to 2**ADDR_W.
- flag_o:
  - MODE 0: level_o == 0.
  - MODE 1: level_o == 2**ADDR_W. This equals wrap bits differing while lower bits match.
- almost_o:
  - MODE 0: level_o <= ALMOST_TH.
  - MODE 1: level_o >= 2**ADDR_W - ALMOST_TH.
- flag_o, almost_o and level_o depend combinationally on local_bin_i and the registered last stage. A local pointer move is reflected in the same cycle, so status errs conservatively.
- Warm-up counter: 0..SYNC_STAGES, cleared by reset, increments each cycle until saturated.
  - valid_o = (count == SYNC_STAGES).
  - While valid_o = 0, flag_o and almost_o are forced to 1 and level_o is forced to 0 (MODE 0) or 2**ADDR_W (MODE 1).
- Reset mid-operation: all stages, the counter and gray_err_o clear on the next edge with rst low. Warm-up restarts after rst returns high.

## Timing
- Reset values:
  - Stages: 0.
  - remote_bin_o: 0.
  - valid_o: 0.
  - flag_o: 1.
  - almost_o: 1.
  - gray_err_o: 0.
  - level_o: 0 (MODE 0) or 2**ADDR_W (MODE 1).
- Latency, remote_gray_i to remote_bin_o: SYNC_STAGES clk edges.
- Latency, local_bin_i to status: 0 cycles (combinational).
- valid_o rises after SYNC_STAGES edges with rst high.
- Simultaneous local and remote pointer updates: the local update is seen immediately and the remote update after SYNC_STAGES edges. There is no special arbitration.
- Wrap-around is handled by modular subtraction. No special case is needed at the pointer MSB.

## Configuration
- PTR_SYNCH_GRAY_CHK_EN defined:
  - Compare the last stage with the previous value of the last stage.
  - If more than one bit differs after valid_o = 1, set gray_err_o on the next edge.
  - gray_err_o holds until reset.
- PTR_SYNCH_GRAY_CHK_EN undefined: gray_err_o is tied to 0 and no checker logic is built.

## Test plan
All scenarios use ADDR_W=4 and SYNC_STAGES=2.
- Reset with rst=0 for 3 cycles, then release -> all outputs hold reset values; valid_o=1 exactly 2 edges after release.
- MODE 0, local_bin_i=0; remote_gray_i steps 0→1→3 (binary 0, 1, 2) -> remote_bin_o follows 2 edges later; level_o goes 0, 1, 2; flag_o falls with level 1; almost_o stays 1 (ALMOST_TH=2).
- MODE 1, local_bin_i=5'b10011, remote_gray_i=5'b00010 (binary 3) -> level_o=16, flag_o=1. Then remote_gray_i=5'b00110 (binary 4) -> flag_o=0 and level_o=15 after 2 edges.
- Wrap-around in MODE 0: local_bin_i=5'b11111, remote pointer binary 0 (Gray 0) -> level_o=1, flag_o=0. Then local_bin_i=0 -> flag_o=1 in the same cycle.
- With PTR_SYNCH_GRAY_CHK_EN defined, after warm-up, change remote_gray_i from 5'b00000 to 5'b00011 -> gray_err_o=1 three edges later and stays 1. Without the macro, gray_err_o stays 0.
- Reset mid-operation: MODE 0 with level_o=5, assert rst for 1 cycle -> remote_bin_o=0, valid_o=0, flag_o=1 on the next edge; warm-up repeats.
